// File: rtl/mips_cpu_pc_control.sv
// PC / control-transfer stage: next-PC selection with one branch-delay slot,
// link-register writeback requests and halt on a committed jump to HALT_ADDR.
module mips_cpu_pc_control #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  rt_index,
  input  logic [4:0]  rd_index,
  input  logic [15:0] immediate,
  input  logic [25:0] target,
  input  logic [31:0] rs_content,
  input  logic        sig_branch,
  output logic [31:0] pc,
  output logic        in_delay_slot,
  output logic        link_write,
  output logic [4:0]  link_reg,
  output logic [31:0] link_addr,
  output logic        active
);

  typedef enum logic [1:0] {RUN, DELAY, HALTED} state_t;

  state_t      state, state_nx;
  logic [31:0] pending, pending_nx, pc_nx, pc_plus4, br_target, xfer_target;
  logic        active_nx;
  logic        is_j, is_jal, is_jr, is_jalr, is_br, is_regimm, is_al, taken;

  assign pc_plus4  = pc + 32'd4;
  assign br_target = pc_plus4 + {{14{immediate[15]}}, immediate, 2'b00};

  assign is_j      = (opcode == 6'h02);
  assign is_jal    = (opcode == 6'h03);
  assign is_jr     = (opcode == 6'h00) && (funct == 6'h08);
  assign is_jalr   = (opcode == 6'h00) && (funct == 6'h09);
  assign is_br     = (opcode >= 6'h04) && (opcode <= 6'h07);
  assign is_regimm = (opcode == 6'h01) &&
                     (rt_index == 5'h00 || rt_index == 5'h01 ||
                      rt_index == 5'h10 || rt_index == 5'h11);
  // BLTZAL/BGEZAL link regardless of the branch outcome
  assign is_al     = (opcode == 6'h01) && (rt_index == 5'h10 || rt_index == 5'h11);

  assign taken = is_j || is_jal || is_jr || is_jalr ||
                 ((is_br || is_regimm) && sig_branch);

  always_comb begin
    xfer_target = br_target;
    if (is_j || is_jal)       xfer_target = {pc_plus4[31:28], target, 2'b00};
    else if (is_jr || is_jalr) xfer_target = rs_content;
  end

  assign link_write    = advance && active && !reset && (is_jal || is_jalr || is_al);
  assign link_reg      = is_jalr ? rd_index : 5'd31;
  assign link_addr     = pc + 32'd8;
  assign in_delay_slot = (state == DELAY);

  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    pending_nx = pending;
    active_nx  = active;
    if (advance) begin
      case (state)
        RUN: begin
          pc_nx = pc_plus4;
          if (taken) begin
            pending_nx = xfer_target;
            state_nx   = DELAY;
          end
        end
        // transfers decoded in the delay slot are deliberately dropped
        DELAY: begin
          if (pending == HALT_ADDR) begin
            pc_nx     = HALT_ADDR;
            active_nx = 1'b0;
            state_nx  = HALTED;
          end else begin
            pc_nx    = pending;
            state_nx = RUN;
          end
        end
        default: pc_nx = HALT_ADDR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      pc      <= RESET_VECTOR;
      pending <= 32'd0;
      active  <= 1'b1;
    end else begin
      state   <= state_nx;
      pc      <= pc_nx;
      pending <= pending_nx;
      active  <= active_nx;
    end
  end

endmodule

// File: tb/tb_mips_cpu_pc_control.sv
// Directed-vector bench: the driver queues hand-computed expectations, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_mips_cpu_pc_control;

  typedef struct packed {
    logic [31:0] pc;
    logic        dly;
    logic        lw;
    logic [4:0]  lreg;
    logic [31:0] laddr;
    logic        act;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        advance = 1'b0;
  logic [5:0]  opcode = '0, funct = '0;
  logic [4:0]  rt_index = '0, rd_index = '0;
  logic [15:0] immediate = '0;
  logic [25:0] target = '0;
  logic [31:0] rs_content = '0;
  logic        sig_branch = 1'b0;
  logic [31:0] pc, link_addr;
  logic        in_delay_slot, link_write, active;
  logic [4:0]  link_reg;

  obs_t  exp_q[$];
  string name_q[$];
  int    total = 0, bad = 0;
  bit    drv_done = 1'b0;

  mips_cpu_pc_control dut (
    .clk(clk), .reset(reset), .advance(advance), .opcode(opcode), .funct(funct),
    .rt_index(rt_index), .rd_index(rd_index), .immediate(immediate), .target(target),
    .rs_content(rs_content), .sig_branch(sig_branch), .pc(pc),
    .in_delay_slot(in_delay_slot), .link_write(link_write), .link_reg(link_reg),
    .link_addr(link_addr), .active(active)
  );

  always #5 clk = ~clk;

  task automatic cyc(input string nm, input logic rst, input logic adv,
                     input logic [5:0] op, input logic [5:0] fn,
                     input logic [4:0] rt, input logic [4:0] rd,
                     input logic [15:0] imm, input logic [25:0] tg,
                     input logic [31:0] rsc, input logic sb,
                     input logic [31:0] epc, input logic edly, input logic elw,
                     input logic [4:0] elreg, input logic eact);
    obs_t e;
    @(posedge clk);
    #2;
    reset = rst; advance = adv; opcode = op; funct = fn; rt_index = rt;
    rd_index = rd; immediate = imm; target = tg; rs_content = rsc; sig_branch = sb;
    e.pc = epc; e.dly = edly; e.lw = elw; e.lreg = elreg;
    e.laddr = epc + 32'd8; e.act = eact;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    obs_t a, e;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = '{pc, in_delay_slot, link_write, link_reg, link_addr, active};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got pc=%h dly=%b lw=%b lreg=%0d laddr=%h act=%b want pc=%h dly=%b lw=%b lreg=%0d laddr=%h act=%b",
                 nm, a.pc, a.dly, a.lw, a.lreg, a.laddr, a.act,
                 e.pc, e.dly, e.lw, e.lreg, e.laddr, e.act);
      end
    end
  end

  initial begin
    //    name        rst adv op     fn     rt     rd    imm       tgt          rs            sb  pc            dly lw lreg act
    cyc("reset",      1, 0, 6'h00, 6'h00, 5'h00, 5'd0, 16'h0000, 26'h0,       32'h0,        0, 32'hBFC00000, 0, 0, 31, 1);
    cyc("nop0",       0, 1, 6'h00, 6'h00, 5'h00, 5'd0, 16'h0000, 26'h0,       32'h0,        0, 32'hBFC00000, 0, 0, 31, 1);
    cyc("stall1",     0, 0, 6'h00, 6'h00, 5'h00, 5'd0, 16'h0000, 26'h0,       32'h0,        0, 32'hBFC00004, 0, 0, 31, 1);
    cyc("nop1",       0, 1, 6'h00, 6'h00, 5'h00, 5'd0, 16'h0000, 26'h0,       32'h0,        0, 32'hBFC00004, 0, 0, 31, 1);
    cyc("stall2",     0, 0, 6'h00, 6'h00, 5'h00, 5'd0, 16'h0000, 26'h0,       32'h0,        0, 32'hBFC00008, 0, 0, 31, 1);
    cyc("nop2",       0, 1, 6'h00, 6'h00, 5'h00, 5'd0, 16'h0000, 26'h0,       32'h0,        0, 32'hBFC00008, 0, 0, 31, 1);
    cyc("nop3",       0, 1, 6'h00, 6'h00, 5'h00, 5'd0, 16'h0000, 26'h0,       32'h0,        0, 32'hBFC0000C, 0, 0, 31, 1);
    cyc("beq_taken",  0, 1, 6'h04, 6'h00, 5'h00, 5'd0, 16'h0003, 26'h0,       32'h0,        1, 32'hBFC00010, 0, 0, 31, 1);
    cyc("beq_slot",   0, 1, 6'h00, 6'h00, 5'h00, 5'd0, 16'h0000, 26'h0,       32'h0,        0, 32'hBFC00014, 1, 0, 31, 1);
    cyc("bne_not",    0, 1, 6'h05, 6'h00, 5'h00, 5'd0, 16'h0003, 26'h0,       32'h0,        0, 32'hBFC00020, 0, 0, 31, 1);
    cyc("bne_seq",    0, 1, 6'h00, 6'h00, 5'h00, 5'd0, 16'h0000, 26'h0,       32'h0,        0, 32'hBFC00024, 0, 0, 31, 1);
    cyc("beq_to40",   0, 1, 6'h04, 6'h00, 5'h00, 5'd0, 16'h0005, 26'h0,       32'h0,        1, 32'hBFC00028, 0, 0, 31, 1);
    cyc("slot_stall", 0, 0, 6'h02, 6'h00, 5'h00, 5'd0, 16'h0000, 26'h0,       32'h0,        0, 32'hBFC0002C, 1, 0, 31, 1);
    cyc("slot_j_ign", 0, 1, 6'h02, 6'h00, 5'h00, 5'd0, 16'h0000, 26'h0,       32'h0,        0, 32'hBFC0002C, 1, 0, 31, 1);
    cyc("jal",        0, 1, 6'h03, 6'h00, 5'h00, 5'd0, 16'h0000, 26'h100,     32'h0,        0, 32'hBFC00040, 0, 1, 31, 1);
    cyc("slot_bgezal",0, 1, 6'h01, 6'h00, 5'h11, 5'd0, 16'h0000, 26'h0,       32'h0,        0, 32'hBFC00044, 1, 1, 31, 1);
    cyc("bgezal_not", 0, 1, 6'h01, 6'h00, 5'h11, 5'd0, 16'h0010, 26'h0,       32'h0,        0, 32'hB0000400, 0, 1, 31, 1);
    cyc("bltz_neg",   0, 1, 6'h01, 6'h00, 5'h00, 5'd0, 16'hFFFF, 26'h0,       32'h0,        1, 32'hB0000404, 0, 0, 31, 1);
    cyc("neg_slot",   0, 1, 6'h00, 6'h00, 5'h00, 5'd0, 16'h0000, 26'h0,       32'h0,        0, 32'hB0000408, 1, 0, 31, 1);
    cyc("jr_top",     0, 1, 6'h00, 6'h08, 5'h00, 5'd0, 16'h0000, 26'h0,       32'hFFFFFFFC, 0, 32'hB0000404, 0, 0, 31, 1);
    cyc("jr_slot",    0, 1, 6'h00, 6'h00, 5'h00, 5'd0, 16'h0000, 26'h0,       32'h0,        0, 32'hB0000408, 1, 0, 31, 1);
    cyc("pc_top",     0, 1, 6'h00, 6'h00, 5'h00, 5'd0, 16'h0000, 26'h0,       32'h0,        0, 32'hFFFFFFFC, 0, 0, 31, 1);
    cyc("wrap_nohalt",0, 1, 6'h00, 6'h00, 5'h00, 5'd0, 16'h0000, 26'h0,       32'h0,        0, 32'h00000000, 0, 0, 31, 1);
    cyc("jalr_halt",  0, 1, 6'h00, 6'h09, 5'h00, 5'd5, 16'h0000, 26'h0,       32'h0,        0, 32'h00000004, 0, 1, 5,  1);
    cyc("halt_slot",  0, 1, 6'h00, 6'h00, 5'h00, 5'd0, 16'h0000, 26'h0,       32'h0,        0, 32'h00000008, 1, 0, 31, 1);
    cyc("halted_jal", 0, 1, 6'h03, 6'h00, 5'h00, 5'd0, 16'h0000, 26'h100,     32'h0,        0, 32'h00000000, 0, 0, 31, 0);
    cyc("halted_nop", 0, 1, 6'h00, 6'h00, 5'h00, 5'd0, 16'h0000, 26'h0,       32'h0,        0, 32'h00000000, 0, 0, 31, 0);
    cyc("rst_again",  1, 0, 6'h00, 6'h00, 5'h00, 5'd0, 16'h0000, 26'h0,       32'h0,        0, 32'hBFC00000, 0, 0, 31, 1);
    cyc("beq_pre_rst",0, 1, 6'h04, 6'h00, 5'h00, 5'd0, 16'h0003, 26'h0,       32'h0,        1, 32'hBFC00000, 0, 0, 31, 1);
    cyc("rst_in_slot",1, 1, 6'h03, 6'h00, 5'h00, 5'd0, 16'h0000, 26'h100,     32'h0,        0, 32'hBFC00000, 0, 0, 31, 1);
    cyc("post_rst0",  0, 1, 6'h00, 6'h00, 5'h00, 5'd0, 16'h0000, 26'h0,       32'h0,        0, 32'hBFC00000, 0, 0, 31, 1);
    cyc("post_rst1",  0, 1, 6'h00, 6'h00, 5'h00, 5'd0, 16'h0000, 26'h0,       32'h0,        0, 32'hBFC00004, 0, 0, 31, 1);
    drv_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    wait (drv_done);
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    if (total < 32) begin
      bad++;
      $display("FAIL count: only %0d checks made, want 32", total);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, total=%0d", total);
    $fatal(1);
  end

endmodule

// File: doc/mips_cpu_pc_control.md
Name: mips_cpu_pc_control

Overview:
Program-counter and control-transfer stage sitting directly downstream of the ALU. It consumes the ALU's branch decision and the decoded instruction fields, and computes the next PC with MIPS single branch-delay-slot semantics. It generates link-register writeback requests (JAL, JALR, BLTZAL, BGEZAL) and detects the halt condition: a control transfer to address 0x00000000 stops execution and deasserts active.

Parameters:
RESET_VECTOR, 32'hBFC00000, PC value loaded on reset
HALT_ADDR, 32'h00000000, committed jump target that halts the CPU

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
advance  input  1  current instruction commits this cycle; PC and state update only when high
opcode  input  6  instruction[31:26]
funct  input  6  instruction[5:0]
rt_index  input  5  instruction[20:16]
rd_index  input  5  instruction[15:11]
immediate  input  16  instruction[15:0]
target  input  26  instruction[25:0]
rs_content  input  32  register rs value (JR/JALR target)
sig_branch  input  1  ALU conditional-branch taken flag
pc  output  32  address of the current instruction
in_delay_slot  output  1  current instruction is a branch-delay slot
link_write  output  1  write link_addr to link_reg this cycle
link_reg  output  5  destination register for the link write
link_addr  output  32  pc + 8
active  output  1  high while the CPU runs; low after halt

Behaviour:
- Reset, asynchronous, any state: pc=RESET_VECTOR, state=RUN, pending_target=0, in_delay_slot=0, active=1. link_write is 0 while reset is high.
- States:
  - RUN: no transfer pending.
  - DELAY: current instruction is a delay slot; pending_target is valid.
  - HALTED: execution stopped.
- Control-transfer decode of the current instruction (combinational):
  - J (02) and JAL (03): target {pc_plus4[31:28], target, 2'b00}.
  - JR (op 00, funct 08) and JALR (op 00, funct 09): target rs_content, low 2 bits passed through unmodified.
  - BEQ/BNE/BLEZ/BGTZ (04-07) and REGIMM (01, rt 00/01/10/11): taken iff sig_branch=1.
  - Branch target = pc_plus4 + {sext(immediate),2'b00}, with 32-bit wrap-around.
- Link request:
  - link_write = advance & active & (JAL | JALR | REGIMM with rt 10000 or 10001).
  - Per ISA, BLTZAL/BGEZAL link whether or not the branch is taken.
  - link_reg = 31, except JALR, which uses rd_index.
  - link_addr = pc + 8 always.
- Transitions, evaluated only when advance=1:
  - RUN, transfer taken: pc <= pc+4; pending_target <= computed target; go to DELAY.
  - RUN, no transfer: pc <= pc+4.
  - DELAY:
    - pc <= pending_target; go to RUN.
    - If pending_target == HALT_ADDR: pc <= HALT_ADDR, active <= 0, go to HALTED.
    - Any transfer decoded in the delay slot is ignored (no pending update). Link writes from a delay-slot JAL/JALR/xxxAL still occur.
  - HALTED: advance ignored, pc held at HALT_ADDR, link_write=0.
- advance=0: all state held (memory stall).
- in_delay_slot = (state==DELAY).
- pc wraps 0xFFFFFFFC -> 0x00000000 on sequential increment. This is not a halt: only a committed transfer target triggers halt.
- Latency:
  - Taken transfer affects pc two advances later (delay slot executes first).
  - link outputs are valid in the same cycle as the linking instruction.

Test Plan:
- Reset: assert reset mid-DELAY -> immediately pc=BFC00000, in_delay_slot=0, active=1, link_write=0.
- Sequential with stalls: 3 NOP advances with advance=0 cycles interleaved -> pc BFC00004, BFC00008, BFC0000C; pc unchanged on stall cycles.
- BEQ taken at pc=BFC00010, imm=0x0003, sig_branch=1 -> next pc BFC00014 with in_delay_slot=1, then pc BFC00020. BNE with sig_branch=0 -> BFC00014, BFC00018.
- JAL at pc=BFC00040, target=0x0000100 -> link_write=1, link_reg=31, link_addr=BFC00048; after delay slot, pc=B0000400.
- JALR rd=5, rs_content=0x00000000 -> link_write=1, link_reg=5; after delay slot, active=0, pc=0, further advances ignored.
- BGEZAL not taken (sig_branch=0) -> link_write=1, pc continues sequentially. Negative offset imm=0xFFFF taken -> target = pc+4-4 = pc.
